// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, divider depth.
// Pure declarations; no timing or flow-control behaviour lives here.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 5;

    function automatic logic md_op_known(input logic [2:0] op);
        return op <= MD_MTLO;
    endfunction

endpackage

// File: rtl/md_unit_div_core.sv
// Unsigned DW/DW restoring divider: one quotient bit per cycle, DW cycles after start.
// No backpressure; start restarts it, abort drops busy at the next edge.
module div_core #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder
);

    localparam int CW = $clog2(DW);

    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] dvs_q, dvs_d;

    logic [DW:0]   shifted;
    logic [DW:0]   diff;

    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        shifted = {rem_q, quo_q[DW-1]};
        diff    = shifted - {1'b0, dvs_q};

        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
        end else if (busy_q) begin
            // Partial remainder stays below the divisor, so a non-negative diff always fits DW bits.
            if (!diff[DW]) begin
                rem_d = diff[DW-1:0];
                quo_d = {quo_q[DW-2:0], 1'b1};
            end else begin
                rem_d = shifted[DW-1:0];
                quo_d = {quo_q[DW-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DW - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign busy      = busy_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/md_unit.sv
// HI/LO owner executing MULT/MULTU (MUL_LAT cycles), DIV/DIVU (33 cycles), MTHI/MTLO (immediate).
// Backpressure: stall is raised combinationally while busy and an op or HI/LO read is presented.
module md_unit
    import md_pkg::*;
#(
    parameter int DW      = 32,
    parameter int MUL_LAT = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          op_valid,
    input  logic [2:0]    op,
    input  logic [DW-1:0] src_a,
    input  logic [DW-1:0] src_b,
    input  logic          mf_req,
    input  logic          cancel,
    output logic          busy,
    output logic          stall,
    output logic          done,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);

    localparam int PW = 2 * DW;

    md_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]           a_q, a_d;
    logic [DW-1:0]           b_q, b_d;
    logic                    div_sgn_q, div_sgn_d;
    logic [DW-1:0]           hi_q, hi_d;
    logic [DW-1:0]           lo_q, lo_d;
    logic                    done_q, done_d;
    logic [MUL_LAT-1:0][PW-1:0] mul_pipe_q, mul_pipe_d;

    logic          accept;
    logic          is_mul;
    logic          is_div;
    logic          div_signed;
    logic [PW-1:0] mul_a;
    logic [PW-1:0] mul_b;
    logic [PW-1:0] product;
    logic [DW-1:0] div_dividend;
    logic [DW-1:0] div_divisor;
    logic          mul_last;
    logic          div_last;
    logic          div_busy;
    logic [DW-1:0] div_quo;
    logic [DW-1:0] div_rem;
    logic          q_neg;
    logic          r_neg;
    logic [DW-1:0] fix_hi;
    logic [DW-1:0] fix_lo;

    assign accept     = op_valid & ~cancel & (state_q == ST_IDLE) & md_op_known(op);
    assign is_mul     = (op == MD_MULT) | (op == MD_MULTU);
    assign is_div     = (op == MD_DIV)  | (op == MD_DIVU);
    assign div_signed = (op == MD_DIV);

    // Sign- or zero-extend to full width so one unsigned multiply serves both flavours.
    assign mul_a   = (op == MD_MULT) ? {{DW{src_a[DW-1]}}, src_a} : {{DW{1'b0}}, src_a};
    assign mul_b   = (op == MD_MULT) ? {{DW{src_b[DW-1]}}, src_b} : {{DW{1'b0}}, src_b};
    assign product = mul_a * mul_b;

    assign div_dividend = (div_signed & src_a[DW-1]) ? -src_a : src_a;
    assign div_divisor  = (div_signed & src_b[DW-1]) ? -src_b : src_b;

    assign mul_last = (cnt_q == CNT_W'(MUL_LAT - 1));
    assign div_last = (cnt_q == CNT_W'(DIV_ITERS - 1));

    div_core #(.DW(DW)) u_div_core (
        .clk       (clk),
        .resetn    (resetn),
        .start     (accept & is_div),
        .abort     (cancel),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .busy      (div_busy),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // 0x8000_0000 / -1 falls out naturally: negating 2^31 wraps back to itself.
    assign q_neg  = div_sgn_q & (a_q[DW-1] ^ b_q[DW-1]);
    assign r_neg  = div_sgn_q & a_q[DW-1];
    assign fix_lo = (b_q == '0) ? '1  : (q_neg ? -div_quo : div_quo);
    assign fix_hi = (b_q == '0) ? a_q : (r_neg ? -div_rem : div_rem);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && is_mul) begin
                    state_d = ST_MUL;
                end else if (accept && is_div) begin
                    state_d = ST_DIV;
                end
            end
            ST_MUL: begin
                if (cancel || mul_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (div_last || !div_busy) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        div_sgn_d  = div_sgn_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        mul_pipe_d = mul_pipe_q;
        for (int i = 1; i < MUL_LAT; i++) begin
            mul_pipe_d[i] = mul_pipe_q[i-1];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (op == MD_MTHI) begin
                        hi_d = src_a;
                    end else if (op == MD_MTLO) begin
                        lo_d = src_a;
                    end else if (is_mul) begin
                        mul_pipe_d[0] = product;
                    end else begin
                        a_d       = src_a;
                        b_d       = src_b;
                        div_sgn_d = div_signed;
                    end
                end
            end
            ST_MUL: begin
                if (cancel || mul_last) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!cancel && mul_last) begin
                    {hi_d, lo_d} = mul_pipe_q[MUL_LAT-1];
                    done_d       = 1'b1;
                end
            end
            ST_DIV: begin
                if (cancel || div_last) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FIX: begin
                if (!cancel) begin
                    hi_d   = fix_hi;
                    lo_d   = fix_lo;
                    done_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            div_sgn_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            mul_pipe_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            div_sgn_q  <= div_sgn_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            mul_pipe_q <= mul_pipe_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign stall = (op_valid | mf_req) & busy & ~cancel;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
